// File: rtl/alu_exec_pkg.sv
// Shared definitions for the execute-stage ALU: operation codes, FSM state
// codes, datapath width and iteration-counter constants.
package alu_exec_pkg;

    localparam int DATA_W = 32;

    // Operation codes driven on ALUOp.
    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_NOR   = 4'd5;
    localparam logic [3:0] OP_SLT   = 4'd6;
    localparam logic [3:0] OP_SLTU  = 4'd7;
    localparam logic [3:0] OP_SLL   = 4'd8;
    localparam logic [3:0] OP_SRL   = 4'd9;
    localparam logic [3:0] OP_SRA   = 4'd10;
    localparam logic [3:0] OP_MULTU = 4'd11;
    localparam logic [3:0] OP_DIVU  = 4'd12;
    localparam logic [3:0] OP_MFHI  = 4'd13;
    localparam logic [3:0] OP_MFLO  = 4'd14;

    // Sequencer states.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_FIN  = 2'd3;

    // Multi-cycle ops retire one bit per cycle; counter runs 0..ITER_LAST.
    localparam int         CNT_W     = 6;
    localparam logic [5:0] ITER_LAST = 6'd31;

    // True for the opcodes handled by the iterative multiply/divide unit.
    function automatic logic is_md_op(input logic [3:0] op);
        return (op == OP_MULTU) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/md_unit.sv
// Iterative unsigned multiply / restoring divide datapath.
// Both operations share one 64-bit accumulator {acc_hi, acc_lo}:
//   multiply: acc_lo starts as the multiplier and shifts right, the product
//             builds up from the top; ends as {hi, lo} = product.
//   divide:   acc_lo starts as the dividend and shifts left, quotient bits
//             enter at the bottom; ends as hi = remainder, lo = quotient.
// A zero divisor preloads the final answer so the sequencer can skip
// straight to commit.
module md_unit
    import alu_exec_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              load_div,
    input  logic              step,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              iter_last,
    output logic [DATA_W-1:0] acc_hi,
    output logic [DATA_W-1:0] acc_lo
);

    logic [DATA_W-1:0] acc_hi_reg, acc_hi_next;
    logic [DATA_W-1:0] acc_lo_reg, acc_lo_next;
    logic [DATA_W-1:0] operand_reg;
    logic              div_mode_reg;
    logic [CNT_W-1:0]  cnt_reg;

    logic [DATA_W:0]   mul_sum;
    logic [DATA_W:0]   div_shift;
    logic [DATA_W+1:0] div_trial;

    assign iter_last = (cnt_reg == ITER_LAST);
    assign acc_hi    = acc_hi_reg;
    assign acc_lo    = acc_lo_reg;

    // Add-shift for multiply, trial-subtract for divide (borrow = restore).
    always_comb begin
        mul_sum     = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, operand_reg} : '0);
        div_shift   = {acc_hi_reg, acc_lo_reg[DATA_W-1]};
        div_trial   = {1'b0, div_shift} - {2'b00, operand_reg};
        acc_hi_next = acc_hi_reg;
        acc_lo_next = acc_lo_reg;
        if (div_mode_reg) begin
            if (!div_trial[DATA_W+1]) begin
                acc_hi_next = div_trial[DATA_W-1:0];
                acc_lo_next = {acc_lo_reg[DATA_W-2:0], 1'b1};
            end else begin
                acc_hi_next = div_shift[DATA_W-1:0];
                acc_lo_next = {acc_lo_reg[DATA_W-2:0], 1'b0};
            end
        end else begin
            acc_hi_next = mul_sum[DATA_W:1];
            acc_lo_next = {mul_sum[0], acc_lo_reg[DATA_W-1:1]};
        end
    end

    // Operand capture on load, one iteration per step cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_hi_reg   <= '0;
            acc_lo_reg   <= '0;
            operand_reg  <= '0;
            div_mode_reg <= 1'b0;
            cnt_reg      <= '0;
        end else if (load) begin
            div_mode_reg <= load_div;
            cnt_reg      <= '0;
            if (load_div) begin
                operand_reg <= op_b;
                if (op_b == '0) begin
                    acc_hi_reg <= op_a;
                    acc_lo_reg <= '1;
                end else begin
                    acc_hi_reg <= '0;
                    acc_lo_reg <= op_a;
                end
            end else begin
                operand_reg <= op_a;
                acc_hi_reg  <= '0;
                acc_lo_reg  <= op_b;
            end
        end else if (step) begin
            acc_hi_reg <= acc_hi_next;
            acc_lo_reg <= acc_lo_next;
            cnt_reg    <= iter_last ? '0 : cnt_reg + 6'd1;
        end
    end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle arithmetic/logic/shift ops plus HI/LO
// moves, and a sequencer driving md_unit for MULTU/DIVU.
// A new op may be accepted in the FIN cycle; if it is a single-cycle op it
// reads HI/LO before the commit and its result takes the result register.
module alu_exec
    import alu_exec_pkg::*;
(
    input  logic        CLK,
    input  logic        Reset,
    input  logic        start,
    input  logic [3:0]  ALUOp,
    input  logic [31:0] rega,
    input  logic [31:0] regb,
    output logic [31:0] result,
    output logic        zero,
    output logic        sign,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    logic [1:0]        state_reg, state_next;
    logic [DATA_W-1:0] result_reg, hi_reg, lo_reg;
    logic              zero_reg, sign_reg, done_reg;

    logic              busy_int;
    logic              accept;
    logic              md_start;
    logic [DATA_W-1:0] alu_val;
    logic [DATA_W-1:0] and_val, or_val, xor_val, nor_val;
    logic              md_last;
    logic [DATA_W-1:0] md_hi, md_lo;

    assign busy_int = (state_reg == ST_MUL) || (state_reg == ST_DIV);
    assign accept   = start && !busy_int;
    assign md_start = accept && is_md_op(ALUOp);

    // Bitwise logic lanes.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_lane
            assign and_val[gi] = rega[gi] & regb[gi];
            assign or_val[gi]  = rega[gi] | regb[gi];
            assign xor_val[gi] = rega[gi] ^ regb[gi];
            assign nor_val[gi] = ~(rega[gi] | regb[gi]);
        end
    endgenerate

    // Single-cycle operation result.
    always_comb begin
        alu_val = '0;
        case (ALUOp)
            OP_ADD:  alu_val = rega + regb;
            OP_SUB:  alu_val = rega - regb;
            OP_AND:  alu_val = and_val;
            OP_OR:   alu_val = or_val;
            OP_XOR:  alu_val = xor_val;
            OP_NOR:  alu_val = nor_val;
            OP_SLT:  alu_val = {{(DATA_W-1){1'b0}}, ($signed(rega) < $signed(regb))};
            OP_SLTU: alu_val = {{(DATA_W-1){1'b0}}, (rega < regb)};
            OP_SLL:  alu_val = regb << rega[4:0];
            OP_SRL:  alu_val = regb >> rega[4:0];
            OP_SRA:  alu_val = $unsigned($signed(regb) >>> rega[4:0]);
            OP_MFHI: alu_val = hi_reg;
            OP_MFLO: alu_val = lo_reg;
            default: alu_val = '0;
        endcase
    end

    // Sequencer next-state; divide by zero skips iteration entirely.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_MUL, ST_DIV: begin
                if (md_last) state_next = ST_FIN;
            end
            default: begin
                state_next = ST_IDLE;
                if (accept && ALUOp == OP_MULTU) begin
                    state_next = ST_MUL;
                end else if (accept && ALUOp == OP_DIVU) begin
                    state_next = (regb == '0) ? ST_FIN : ST_DIV;
                end
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    // Output registers: FIN commit first, a same-cycle single-cycle op overrides result.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            result_reg <= '0;
            zero_reg   <= 1'b1;
            sign_reg   <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (state_reg == ST_FIN) begin
                hi_reg     <= md_hi;
                lo_reg     <= md_lo;
                result_reg <= md_lo;
                zero_reg   <= (md_lo == '0);
                sign_reg   <= md_lo[DATA_W-1];
                done_reg   <= 1'b1;
            end
            if (accept && !is_md_op(ALUOp)) begin
                result_reg <= alu_val;
                zero_reg   <= (alu_val == '0);
                sign_reg   <= alu_val[DATA_W-1];
                done_reg   <= 1'b1;
            end
        end
    end

    md_unit u_md (
        .clk       (CLK),
        .rst       (Reset),
        .load      (md_start),
        .load_div  (ALUOp == OP_DIVU),
        .step      (busy_int),
        .op_a      (rega),
        .op_b      (regb),
        .iter_last (md_last),
        .acc_hi    (md_hi),
        .acc_lo    (md_lo)
    );

    assign result = result_reg;
    assign zero   = zero_reg;
    assign sign   = sign_reg;
    assign hi     = hi_reg;
    assign lo     = lo_reg;
    assign busy   = busy_int;
    assign done   = done_reg;

endmodule
